cr_kme_fifo_rd_packer: RTL
==========================

CR_KME_FIFO_RD_PACKER -- requirements
Module: cr_kme_fifo_rd_packer

Interface
REQ-001 SHALL have a single clock; reset is asynchronous and active-high.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port fifo_out  input  34  FIFO read data: [33]=SOP, [32]=EOP, [31:0]=payload word.
REQ-005 SHALL have port fifo_out_valid  input  1  FIFO non-empty.
REQ-006 SHALL have port fifo_out_ack  output  1  pop strobe to the FIFO (word consumed this cycle).
REQ-007 SHALL have port out_data  output  64  packed beat; low word in [31:0].
REQ-008 SHALL have port out_keep  output  2  lane valid: 2'b01 (low only) or 2'b11.
REQ-009 SHALL have port out_sop  output  1  beat starts a packet.
REQ-010 SHALL have port out_eop  output  1  beat ends a packet.
REQ-011 SHALL have port out_valid  output  1  beat valid.
REQ-012 SHALL have port out_ready  input  1  downstream accept.
REQ-013 SHALL have port proto_err  output  1  sticky framing-error flag.
REQ-014 SHALL have port pkt_count  output  16  completed-packet counter.

Function
REQ-015 SHALL keep a one-beat output register (out_*) plus a 32-bit low-word holding register (lo_data, lo_sop).
REQ-016 SHALL define a slot as free when !out_valid || out_ready.
REQ-017 SHALL drive fifo_out_ack = fifo_out_valid && slot free, combinationally; no other pop condition.
REQ-018 SHALL use the FSM states IDLE (no packet open), EVEN (packet open, holding register empty) and ODD (low word held).
REQ-019 SHALL, in IDLE or EVEN on a popped word without EOP, store the word in lo_data, set lo_sop = (state==IDLE), and go to ODD with no beat issued.
REQ-020 SHALL, in IDLE or EVEN on a popped word with EOP, load the output register with {32'h0, word}, keep=01, sop=(state==IDLE), eop=1, and go to IDLE.
REQ-021 SHALL, in ODD on a popped word, load the output register with {word, lo_data}, keep=11, sop=lo_sop, eop=word[32], and go to IDLE if EOP, else EVEN.
REQ-022 SHALL present a beat on out_valid exactly one cycle after the pop of its final word.
REQ-023 SHALL clear out_valid after a handshake (out_valid && out_ready) when no new beat is loaded in the same cycle.
REQ-024 SHALL support a load and a handshake in the same cycle without a bubble.
REQ-025 SHALL hold out_data, out_keep, out_sop and out_eop stable while out_valid && !out_ready.
REQ-026 SHALL, on a word with SOP=0 popped in IDLE, set proto_err and treat the word as a packet start.
REQ-027 SHALL, on a word with SOP=1 popped in EVEN or ODD, set proto_err and treat the word as a continuation (SOP ignored).
REQ-028 SHALL, on a word with SOP=1 and EOP=1 popped in IDLE, emit a single-word packet beat with no error.
REQ-029 SHALL keep proto_err set until reset.
REQ-030 SHALL never drop or duplicate payload words, including under back-pressure of any length.

Reset
REQ-031 SHALL, while rst=1, asynchronously force the FSM to IDLE, out_valid=0, out_data=0, out_keep=0, out_sop=0, out_eop=0, proto_err=0, pkt_count=0 and lo_data=0.
REQ-032 SHALL hold fifo_out_ack at 0 while rst=1.
REQ-033 SHALL discard any partial packet on reset mid-operation; the next pop is treated as from IDLE.

Configuration
REQ-034 SHALL, with CR_KME_RD_PACKER_STATS_EN defined, increment pkt_count by 1 on each handshake of a beat with out_eop=1, wrapping from 16'hFFFF to 16'h0000.
REQ-035 SHALL, without CR_KME_RD_PACKER_STATS_EN, keep the pkt_count port present, tie it to 16'h0000 and synthesize no counter logic.

Verification
REQ-036 SHALL be covered by this scenario: a 4-word packet A0(SOP)..A3(EOP) with out_ready=1 -> beats {A1,A0} keep=11 sop=1 eop=0, then {A3,A2} keep=11 sop=0 eop=1; proto_err=0.
REQ-037 SHALL be covered by this scenario: a 3-word packet B0..B2 -> second beat is {0,B2} with keep=01 and eop=1; pkt_count increments by 1 (STATS_EN).
REQ-038 SHALL be covered by this scenario: out_ready=0 for 10 cycles with the FIFO full -> exactly 2 pops before a stall, out_* held stable, no word lost after release.
REQ-039 SHALL be covered by this scenario: word SOP=0 in IDLE -> proto_err=1 and it stays 1 through 3 later good packets.
REQ-040 SHALL be covered by this scenario: rst pulse while in ODD -> out_valid=0 and pkt_count=0 immediately; the next SOP+EOP word yields keep=01, sop=1, eop=1.
REQ-041 SHALL be covered by this scenario: 65537 single-word packets with STATS_EN -> pkt_count=1 (wrap).

Source files
------------

// File: rtl/cr_kme_fifo_rd_packer.sv
// ---------------------------------------------------------------------------
// cr_kme_fifo_rd_packer: packs 32-bit FIFO words into 64-bit beats per packet.
// Rev 1.0 -- optional CR_KME_RD_PACKER_STATS_EN enables the pkt_count counter.
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module cr_kme_fifo_rd_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic [33:0] fifo_out,
  input  logic        fifo_out_valid,
  output logic        fifo_out_ack,
  output logic [63:0] out_data,
  output logic [1:0]  out_keep,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        proto_err,
  output logic [15:0] pkt_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVEN = 2'd1,
    ST_ODD  = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_lo_data;
  logic        r_lo_sop;

  logic        w_slot_free;
  logic        w_word_sop;
  logic        w_word_eop;
  logic [31:0] w_word;

  assign w_slot_free  = !out_valid || out_ready;
  assign fifo_out_ack = fifo_out_valid && w_slot_free && !rst;
  assign w_word_sop   = fifo_out[33];
  assign w_word_eop   = fifo_out[32];
  assign w_word       = fifo_out[31:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_lo_data <= 32'h0;
      r_lo_sop  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 64'h0;
      out_keep  <= 2'b00;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      // A load below overrides this clear, giving back-to-back beats.
      if (out_valid && out_ready)
        out_valid <= 1'b0;

      if (fifo_out_ack) begin
        case (r_state)
          ST_IDLE, ST_EVEN: begin
            // Framing errors are flagged but the word is still used as data.
            if ((r_state == ST_IDLE) && !w_word_sop)
              proto_err <= 1'b1;
            if ((r_state == ST_EVEN) && w_word_sop)
              proto_err <= 1'b1;
            if (w_word_eop) begin
              out_valid <= 1'b1;
              out_data  <= {32'h0, w_word};
              out_keep  <= 2'b01;
              out_sop   <= (r_state == ST_IDLE);
              out_eop   <= 1'b1;
              r_state   <= ST_IDLE;
            end else begin
              r_lo_data <= w_word;
              r_lo_sop  <= (r_state == ST_IDLE);
              r_state   <= ST_ODD;
            end
          end
          ST_ODD: begin
            if (w_word_sop)
              proto_err <= 1'b1;
            out_valid <= 1'b1;
            out_data  <= {w_word, r_lo_data};
            out_keep  <= 2'b11;
            out_sop   <= r_lo_sop;
            out_eop   <= w_word_eop;
            r_state   <= w_word_eop ? ST_IDLE : ST_EVEN;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

`ifdef CR_KME_RD_PACKER_STATS_EN
  logic [15:0] r_pkt_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_pkt_count <= 16'h0000;
    else if (out_valid && out_ready && out_eop)
      r_pkt_count <= r_pkt_count + 16'd1;
  end

  assign pkt_count = r_pkt_count;
`else
  assign pkt_count = 16'h0000;
`endif

endmodule

`default_nettype wire
